// File: rtl/fp_div_round_pack_if.sv
// Handshake bundle for the divide post-processing stage.
// Optional out_flags is present when FPDIV_FLAGS_EN is defined.
`timescale 1ns/1ps
interface fp_div_round_pack_if #(
  parameter int K = 23,
  parameter int E = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [E+K:0]   in_a;
  logic [E+K:0]   in_b;
  logic [2*K+1:0] in_q;
  logic           out_valid;
  logic           out_ready;
  logic [E+K:0]   out_result;
`ifdef FPDIV_FLAGS_EN
  logic [4:0]     out_flags;

  modport master (
    output in_valid, in_a, in_b, in_q, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );
  modport slave (
    input  in_valid, in_a, in_b, in_q, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_q, out_ready,
    input  in_ready, out_valid, out_result
  );
  modport slave (
    input  in_valid, in_a, in_b, in_q, out_ready,
    output in_ready, out_valid, out_result
  );
`endif
endinterface

// File: rtl/fp_div_round_pack.sv
// Single-precision divide back end: sign/exponent, normalize, round, pack.
// Define FPDIV_FLAGS_EN to build the IEEE exception flag output.
`timescale 1ns/1ps
module fp_div_round_pack #(
  parameter int K    = 23,
  parameter int E    = 8,
  parameter int BIAS = 127
) (
  input logic               clk,
  input logic               rst,
  fp_div_round_pack_if.slave bus
);

  localparam int W  = 1 + E + K;
  localparam int XW = E + 2;

  localparam logic signed [XW-1:0] XBIAS = XW'(BIAS);
  localparam logic signed [XW-1:0] XMAX  = XW'((1 << E) - 1);
  localparam logic signed [XW-1:0] XZERO = '0;
  localparam logic signed [XW-1:0] XONE  = XW'(1);
  localparam logic [W-1:0] QNAN =
    {1'b0, {E{1'b1}}, 1'b1, {(K-1){1'b0}}};

  logic s1_en;
  logic s2_en;

  logic s1_valid_q, s1_valid_d;
  logic s1_sign_q,  s1_sign_d;
  logic s1_nan_q,   s1_nan_d;
  logic s1_inf_q,   s1_inf_d;
  logic s1_zero_q,  s1_zero_d;
  logic signed [XW-1:0] s1_exp_q, s1_exp_d;
  logic [K+1:0] s1_q_q, s1_q_d;

  logic         out_valid_q,  out_valid_d;
  logic [W-1:0] out_result_q, out_result_d;

  logic [E-1:0] ea, eb;
  logic [K-1:0] fa, fb;
  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;

  logic [K:0]   m_raw;
  logic         grd;
  logic [K+1:0] m_sum;
  logic [K:0]   m_fin;
  logic signed [XW-1:0] x_fin;
  logic ar, ovf, unf;
  logic [W-1:0] res;

  logic unused_ok;

  assign s2_en        = !out_valid_q || bus.out_ready;
  assign s1_en        = !s1_valid_q || s2_en;
  assign bus.in_ready = s1_en;

  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;

  assign ea = bus.in_a[E+K-1:K];
  assign eb = bus.in_b[E+K-1:K];
  assign fa = bus.in_a[K-1:0];
  assign fb = bus.in_b[K-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);

  // Stage 1: classify operands, form exponent, capture low quotient bits
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_nan_d   = s1_nan_q;
    s1_inf_d   = s1_inf_q;
    s1_zero_d  = s1_zero_q;
    s1_exp_d   = s1_exp_q;
    s1_q_d     = s1_q_q;
    if (s1_en) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_sign_d = bus.in_a[W-1] ^ bus.in_b[W-1];
        s1_nan_d  = a_nan || b_nan ||
                    (a_zero && b_zero) ||
                    (a_inf && b_inf);
        s1_inf_d  = !s1_nan_d && (b_zero || a_inf);
        s1_zero_d = !s1_nan_d && !s1_inf_d &&
                    (a_zero || b_inf);
        s1_exp_d  = $signed({2'b00, ea})
                  - $signed({2'b00, eb})
                  + XBIAS
                  - $signed({{(XW-1){1'b0}}, !bus.in_q[K+1]});
        s1_q_d    = bus.in_q[K+1:0];
      end
    end
  end

  // Stage 2: normalize, round half-up on guard, saturate, pack
  always_comb begin
    if (s1_q_q[K+1]) begin
      m_raw = s1_q_q[K+1:1];
      grd   = s1_q_q[0];
    end else begin
      m_raw = s1_q_q[K:0];
      grd   = 1'b0;
    end
    m_sum = {1'b0, m_raw} + {{(K+1){1'b0}}, grd};
    if (m_sum[K+1]) begin
      m_fin = {1'b1, {K{1'b0}}};
      x_fin = s1_exp_q + XONE;
    end else begin
      m_fin = m_sum[K:0];
      x_fin = s1_exp_q;
    end
    ar  = !(s1_nan_q || s1_inf_q || s1_zero_q);
    ovf = ar && (x_fin >= XMAX);
    unf = ar && (x_fin <= XZERO);
    res = '0;
    unique case (1'b1)
      s1_nan_q:       res = QNAN;
      s1_inf_q, ovf:  res = {s1_sign_q, {E{1'b1}}, {K{1'b0}}};
      s1_zero_q, unf: res = {s1_sign_q, {(E+K){1'b0}}};
      default:        res = {s1_sign_q, x_fin[E-1:0], m_fin[K-1:0]};
    endcase
  end

  // Output register advances whenever the consumer is not stalling it
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) out_result_d = res;
    end
  end

  // Valid bits and result word with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
    end
  end

  // Stage-1 payload only matters while s1_valid_q is set
  always_ff @(posedge clk) begin
    s1_sign_q <= s1_sign_d;
    s1_nan_q  <= s1_nan_d;
    s1_inf_q  <= s1_inf_d;
    s1_zero_q <= s1_zero_d;
    s1_exp_q  <= s1_exp_d;
    s1_q_q    <= s1_q_d;
  end

`ifdef FPDIV_FLAGS_EN
  logic       s1_dz_q, s1_dz_d;
  logic [4:0] flags_q, flags_d;
  logic [4:0] flg;

  assign bus.out_flags = flags_q;
  assign unused_ok = ^bus.in_q[2*K+1:K+2];

  // Divide-by-zero is only raised for a finite nonzero dividend
  always_comb begin
    s1_dz_d = s1_dz_q;
    if (s1_en && bus.in_valid)
      s1_dz_d = b_zero && !a_zero && !a_inf && !a_nan;
  end

  // Flags: {invalid, divzero, overflow, underflow, inexact}
  always_comb begin
    flg = {s1_nan_q, s1_dz_q, ovf, unf,
           ar && (grd || ovf || (unf && |m_fin))};
    flags_d = flags_q;
    if (s2_en && s1_valid_q) flags_d = flg;
  end

  // Flag payload follows stage-1 data; flag output resets to zero
  always_ff @(posedge clk) begin
    s1_dz_q <= s1_dz_d;
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end
`else
  assign unused_ok = ^{bus.in_q[2*K+1:K+2], m_fin[K]};
`endif

endmodule
